// File: rtl/fifo_in_drain_ctrl_if.sv
// ---------------------------------------------------------------------------
// fifo_in_drain_ctrl_if
// Bundles the two data paths of the FIFO drain sequencer:
//   - read-only bus to the input-FIFO top block (m_sel, m_wr, m_address,
//     m_din driven by the master; m_dout returned one cycle after a request)
//   - valid/ready stream to the downstream consumer (out_valid, out_data
//     driven by the master; out_ready returned by the consumer)
// Modports:
//   master : the sequencer side
//   slave  : the FIFO top plus downstream consumer side
// ---------------------------------------------------------------------------
interface fifo_in_drain_ctrl_if;
    logic        m_sel;
    logic        m_wr;
    logic [7:0]  m_address;
    logic [31:0] m_din;
    logic [31:0] m_dout;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    modport master (
        output m_sel, m_wr, m_address, m_din, out_valid, out_data,
        input  m_dout, out_ready
    );

    modport slave (
        input  m_sel, m_wr, m_address, m_din, out_valid, out_data,
        output m_dout, out_ready
    );
endinterface

// File: rtl/fifo_in_drain_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_in_drain_ctrl
// Bus-master sequencer that drains a programmed number of 32-bit words from
// the input-FIFO top block into a valid/ready consumer. It polls the flag
// register and pops the data port only while the FIFO reports non-empty.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   start, word_cnt   one-cycle start pulse and the word count sampled with it
//   abort             drop the transfer and return to IDLE on the next edge
//   busy, done, err   status: active, one-cycle completion, sticky rd_err
//   bus (master)      FIFO bus + downstream stream, see fifo_in_drain_ctrl_if
// All outputs are registered: the next-cycle values are decoded from the
// next state so they line up with the state they describe.
// ---------------------------------------------------------------------------
module fifo_in_drain_ctrl #(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned POLL_GAP  = 2,
    parameter logic [7:0]  FLAG_ADDR = 8'h10,
    parameter logic [7:0]  DATA_ADDR = 8'h11
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     word_cnt,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    fifo_in_drain_ctrl_if.master bus
);

    // Gap counter only needs to hold 0 .. POLL_GAP-1.
    localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(POLL_GAP - 1);
    localparam int unsigned FLAG_EMPTY_BIT  = 4;
    localparam int unsigned FLAG_RD_ERR_BIT = 0;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_POLL   = 4'd1,
        ST_CHK    = 4'd2,
        ST_GAP    = 4'd3,
        ST_READ   = 4'd4,
        ST_CAPT   = 4'd5,
        ST_HOLD   = 4'd6,
        ST_SETTLE = 4'd7,
        ST_DONE   = 4'd8
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   rem_r, rem_s;
    logic [GAP_W-1:0]   gap_r, gap_s;
    logic               err_r, err_s;
    logic               done_r, done_s;
    logic               busy_r, busy_s;
    logic               m_sel_r, m_sel_s;
    logic [7:0]         m_addr_r, m_addr_s;
    logic               out_valid_r, out_valid_s;
    logic [31:0]        out_data_r, out_data_s;

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_s     = state_r;
        rem_s       = rem_r;
        gap_s       = gap_r;
        err_s       = err_r;
        done_s      = 1'b0;
        out_valid_s = out_valid_r;
        out_data_s  = out_data_r;

        if ((state_r != ST_IDLE) && abort) begin
            // Abort wins over start/out_ready; any held word is discarded.
            state_s     = ST_IDLE;
            out_valid_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (word_cnt == {CNT_W{1'b0}}) begin
                            done_s = 1'b1;
                        end else begin
                            rem_s   = word_cnt;
                            err_s   = 1'b0;
                            state_s = ST_POLL;
                        end
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_POLL: begin
                    state_s = ST_CHK;
                end
                ST_CHK: begin
                    if (bus.m_dout[FLAG_RD_ERR_BIT]) begin
                        err_s = 1'b1;
                    end else begin
                        err_s = err_r;
                    end
                    if (bus.m_dout[FLAG_EMPTY_BIT]) begin
                        gap_s   = GAP_INIT;
                        state_s = ST_GAP;
                    end else begin
                        state_s = ST_READ;
                    end
                end
                ST_GAP: begin
                    if (gap_r == {GAP_W{1'b0}}) begin
                        state_s = ST_POLL;
                    end else begin
                        gap_s = gap_r - GAP_W'(1);
                    end
                end
                ST_READ: begin
                    state_s = ST_CAPT;
                end
                ST_CAPT: begin
                    // rem > 0 is guaranteed here, so no underflow.
                    out_data_s  = bus.m_dout;
                    out_valid_s = 1'b1;
                    rem_s       = rem_r - CNT_W'(1);
                    state_s     = ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_s = 1'b0;
                        if (rem_r == {CNT_W{1'b0}}) begin
                            state_s = ST_DONE;
                        end else begin
                            state_s = ST_SETTLE;
                        end
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                ST_SETTLE: begin
                    // Let the FIFO's registered flag catch up with the pop.
                    state_s = ST_POLL;
                end
                ST_DONE: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s     = ST_IDLE;
                    out_valid_s = 1'b0;
                end
            endcase
        end

        if (state_s == ST_DONE) begin
            done_s = 1'b1;
        end else begin
            done_s = done_s;
        end
        busy_s   = (state_s != ST_IDLE) && (state_s != ST_DONE);
        m_sel_s  = (state_s == ST_POLL) || (state_s == ST_READ);
        if (state_s == ST_POLL) begin
            m_addr_s = FLAG_ADDR;
        end else if (state_s == ST_READ) begin
            m_addr_s = DATA_ADDR;
        end else begin
            m_addr_s = 8'h00;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            rem_r       <= {CNT_W{1'b0}};
            gap_r       <= {GAP_W{1'b0}};
            err_r       <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            m_sel_r     <= 1'b0;
            m_addr_r    <= 8'h00;
            out_valid_r <= 1'b0;
            out_data_r  <= 32'h0000_0000;
        end else begin
            state_r     <= state_s;
            rem_r       <= rem_s;
            gap_r       <= gap_s;
            err_r       <= err_s;
            done_r      <= done_s;
            busy_r      <= busy_s;
            m_sel_r     <= m_sel_s;
            m_addr_r    <= m_addr_s;
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign err           = err_r;
    assign bus.m_sel     = m_sel_r;
    assign bus.m_address = m_addr_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    // Read-only master: write strobe and write data are tied off.
    assign bus.m_wr      = 1'b0;
    assign bus.m_din     = 32'h0000_0000;

endmodule

// File: tb/tb_fifo_in_drain_ctrl.sv
module tb_fifo_in_drain_ctrl;

    localparam logic [7:0] FLAG_A = 8'h10;
    localparam logic [7:0] DATA_A = 8'h11;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [7:0] word_cnt;
    logic       abort;
    logic       busy;
    logic       done;
    logic       err;

    fifo_in_drain_ctrl_if bus ();

    fifo_in_drain_ctrl #(
        .CNT_W     (8),
        .POLL_GAP  (2),
        .FLAG_ADDR (8'h10),
        .DATA_ADDR (8'h11)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .word_cnt (word_cnt),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- FIFO top model ----------------
    logic [31:0] fq[$];
    logic        push_en;
    logic [31:0] push_dat;
    logic        force_flag;
    int          n_data_rd = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.m_dout <= 32'h0;
        end else begin
            if (bus.m_sel && !bus.m_wr) begin
                if (bus.m_address == FLAG_A) begin
                    if (force_flag)
                        bus.m_dout <= 32'h0000_0011;
                    else
                        bus.m_dout <= {26'd0, (fq.size() >= 16), (fq.size() == 0), 4'd0};
                end else if (bus.m_address == DATA_A) begin
                    n_data_rd <= n_data_rd + 1;
                    if (fq.size() != 0)
                        bus.m_dout <= fq.pop_front();
                    else
                        bus.m_dout <= 32'h0;
                end
            end
            if (push_en) fq.push_back(push_dat);
        end
    end

    // ---------------- monitors ----------------
    int          cyc = 0;
    int          n_done = 0;
    int          poll_cyc[$];
    logic [31:0] rx[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready && !abort) rx.push_back(bus.out_data);
        if (done) n_done = n_done + 1;
        if (bus.m_sel && bus.m_address == FLAG_A) poll_cyc.push_back(cyc);
    end

    // ---------------- checking ----------------
    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic        start;
        logic [7:0]  wc;
        logic        e_busy;
        logic        e_done;
        logic        e_sel;
        logic [7:0]  e_addr;
        logic        e_ov;
        logic [31:0] e_data;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t v(input logic st, input logic [7:0] wc, input logic b,
                               input logic d, input logic s, input logic [7:0] a,
                               input logic ov, input logic [31:0] dt);
        vec_t r;
        r.start = st; r.wc = wc; r.e_busy = b; r.e_done = d;
        r.e_sel = s; r.e_addr = a; r.e_ov = ov; r.e_data = dt;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] d);
        push_en  = 1'b1;
        push_dat = d;
        tick();
        push_en  = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        n_vec = n_vec + 1;
        if (!seen) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: done not seen within %0d cycles", nm, budget);
        end
    endtask

    task automatic wait_valid(input int budget, input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        n_vec = n_vec + 1;
        if (!seen) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: out_valid not seen within %0d cycles", nm, budget);
        end
    endtask

    task automatic pulse_start(input logic [7:0] wc);
        start    = 1'b1;
        word_cnt = wc;
        tick();
        start    = 1'b0;
    endtask

    initial begin : main
        int snap_rd, snap_done, snap_poll, snap_rx, nv;
        logic [31:0] d0;

        reset_n = 1'b1; start = 1'b0; word_cnt = 8'd0; abort = 1'b0;
        push_en = 1'b0; push_dat = 32'h0; force_flag = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state (asynchronous: visible without a clock edge).
        #2 reset_n = 1'b0;
        #1;
        chk("reset_outs", {28'd0, busy, done, err, bus.m_sel}, 32'h0);
        chk("reset_addr", {24'd0, bus.m_address}, 32'h0);
        chk("reset_stream", {31'd0, bus.out_valid}, 32'h0);
        chk("reset_data", bus.out_data, 32'h0);
        chk("reset_wr_din", {bus.m_din[30:0], bus.m_wr}, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();

        // ---- table: 3-word drain, start-while-busy, word_cnt=0 ----
        tbl[0]  = v(1'b1, 8'd3, 1'b1, 1'b0, 1'b1, 8'h10, 1'b0, 32'h0);   // POLL
        tbl[1]  = v(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);   // CHK
        tbl[2]  = v(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 32'h0);   // READ
        tbl[3]  = v(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);   // CAPT
        tbl[4]  = v(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 32'hA1);  // HOLD
        tbl[5]  = v(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);   // SETTLE
        tbl[6]  = v(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'h10, 1'b0, 32'h0);   // POLL
        tbl[7]  = v(1'b1, 8'd5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);   // CHK, start ignored
        tbl[8]  = v(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 32'h0);   // READ
        tbl[9]  = v(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);   // CAPT
        tbl[10] = v(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 32'hB2);  // HOLD
        tbl[11] = v(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);   // SETTLE
        tbl[12] = v(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'h10, 1'b0, 32'h0);   // POLL
        tbl[13] = v(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);   // CHK
        tbl[14] = v(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 32'h0);   // READ
        tbl[15] = v(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);   // CAPT
        tbl[16] = v(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 32'hC3);  // HOLD
        tbl[17] = v(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0);   // DONE
        tbl[18] = v(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);   // IDLE
        tbl[19] = v(1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0);   // wc=0 -> done
        tbl[20] = v(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);   // IDLE

        push_word(32'hA1);
        push_word(32'hB2);
        push_word(32'hC3);
        snap_rd   = n_data_rd;
        snap_done = n_done;
        for (int i = 0; i < 21; i++) begin
            start    = tbl[i].start;
            word_cnt = tbl[i].wc;
            tick();
            n_vec = n_vec + 1;
            if ({busy, done, err, bus.m_sel, bus.m_address, bus.out_valid} !==
                {tbl[i].e_busy, tbl[i].e_done, 1'b0, tbl[i].e_sel, tbl[i].e_addr, tbl[i].e_ov} ||
                (tbl[i].e_ov && bus.out_data !== tbl[i].e_data)) begin
                n_miss = n_miss + 1;
                $display("FAIL vec%0d: busy/done/err/sel=%b%b%b%b addr=%h ov=%b data=%h expected %b%b0%b addr=%h ov=%b data=%h",
                         i, busy, done, err, bus.m_sel, bus.m_address, bus.out_valid, bus.out_data,
                         tbl[i].e_busy, tbl[i].e_done, tbl[i].e_sel, tbl[i].e_addr, tbl[i].e_ov, tbl[i].e_data);
            end
        end
        start = 1'b0;
        chk("three_data_reads", n_data_rd - snap_rd, 32'd3);
        chk("table_done_pulses", n_done - snap_done, 32'd2);

        // ---- empty FIFO: polling with gaps, data pushed 20 cycles later ----
        snap_rd   = n_data_rd;
        snap_poll = poll_cyc.size();
        snap_rx   = rx.size();
        pulse_start(8'd2);
        for (int i = 0; i < 19; i++) tick();
        chk("no_data_rd_while_empty", n_data_rd - snap_rd, 32'd0);
        n_vec = n_vec + 1;
        if (poll_cyc.size() - snap_poll < 4) begin
            n_miss = n_miss + 1;
            $display("FAIL poll_count: got %0d polls expected at least 4", poll_cyc.size() - snap_poll);
        end
        nv = 0;
        for (int i = snap_poll + 1; i < poll_cyc.size(); i++)
            if (poll_cyc[i] - poll_cyc[i-1] != 4) nv = nv + 1;
        chk("poll_spacing_violations", nv, 32'd0);
        push_word(32'h2020_0001);
        push_word(32'h2020_0002);
        wait_done(60, "empty_then_push_done");
        chk("empty_rx_count", rx.size() - snap_rx, 32'd2);
        if (rx.size() - snap_rx == 2) begin
            chk("empty_rx_w0", rx[snap_rx], 32'h2020_0001);
            chk("empty_rx_w1", rx[snap_rx+1], 32'h2020_0002);
        end
        tick();

        // ---- backpressure: out_ready low for 7 cycles ----
        push_word(32'h5555_AAAA);
        bus.out_ready = 1'b0;
        snap_done = n_done;
        pulse_start(8'd1);
        wait_valid(20, "bp_valid");
        d0 = bus.out_data;
        chk("bp_data_first", d0, 32'h5555_AAAA);
        nv = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (!bus.out_valid || bus.out_data !== 32'h5555_AAAA || done) nv = nv + 1;
        end
        chk("bp_hold_stable_violations", nv, 32'd0);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_accept_ov_done", {30'd0, bus.out_valid, done}, 32'h1);
        tick();
        chk("bp_done_once", n_done - snap_done, 32'd1);

        // ---- abort during HOLD of word 2 of 4 ----
        push_word(32'h4000_0001);
        push_word(32'h4000_0002);
        push_word(32'h4000_0003);
        push_word(32'h4000_0004);
        snap_done = n_done;
        pulse_start(8'd4);
        nv = 0;
        for (int i = 0; i < 40 && nv < 2; i++) begin
            if (bus.out_valid) nv = nv + 1;
            if (nv < 2) tick();
        end
        chk("abort_reached_word2", nv, 32'd2);
        abort    = 1'b1;
        start    = 1'b1;
        word_cnt = 8'd7;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_idle", {29'd0, busy, bus.out_valid, bus.m_sel}, 32'h0);
        for (int i = 0; i < 5; i++) tick();
        chk("abort_still_idle", {31'd0, busy}, 32'h0);
        chk("abort_no_done", n_done - snap_done, 32'd0);
        chk("abort_fifo_left", fq.size(), 32'd2);
        snap_rx = rx.size();
        pulse_start(8'd2);
        wait_done(40, "after_abort_done");
        chk("after_abort_rx_count", rx.size() - snap_rx, 32'd2);
        if (rx.size() - snap_rx == 2) begin
            chk("after_abort_w3", rx[snap_rx], 32'h4000_0003);
            chk("after_abort_w4", rx[snap_rx+1], 32'h4000_0004);
        end
        tick();

        // ---- forced flag 32'h11: sticky err, cleared by next start ----
        push_word(32'hEEEE_0001);
        force_flag = 1'b1;
        pulse_start(8'd1);          // now in POLL
        tick();                     // CHK, flag returned as 32'h11
        force_flag = 1'b0;
        tick();                     // GAP, err set
        chk("err_set", {31'd0, err}, 32'h1);
        wait_done(40, "err_transfer_done");
        tick();
        chk("err_sticky_after_done", {31'd0, err}, 32'h1);
        push_word(32'hEEEE_0002);
        pulse_start(8'd1);
        chk("err_cleared_by_start", {30'd0, err, busy}, 32'h1);
        wait_done(40, "err_clear_transfer_done");
        tick();

        // ---- asynchronous reset mid-transfer ----
        pulse_start(8'd2);          // FIFO empty: keeps polling
        tick();
        tick();
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_outs", {28'd0, busy, done, err, bus.m_sel}, 32'h0);
        chk("midreset_addr_ov", {23'd0, bus.m_address, bus.out_valid}, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        chk("after_reset_idle", {30'd0, busy, bus.m_sel}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
